// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independently programmable clock dividers.
// Each channel has an active and a shadow divisor/high-time pair. A config
// write lands in the shadow and is applied at the next period wrap or park.
// Optional feature macro: MULTI_CLOCK_DIVIDER_SYNC_EN adds a sync_restart
// input that phase-aligns every enabled channel.
module multi_clock_divider #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock_50MHz,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]  cfg_div,
  input  logic [WIDTH-1:0]  cfg_high,
  output logic              cfg_ack,
  output logic [NUM_CH-1:0] cfg_pending,
  input  logic [NUM_CH-1:0] ch_enable,
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  input  logic              sync_restart,
`endif
  output logic [NUM_CH-1:0] clock_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(DEFAULT_DIV / 2);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV  = WIDTH'(2);

  logic [WIDTH-1:0] act_div  [NUM_CH];
  logic [WIDTH-1:0] act_high [NUM_CH];
  logic [WIDTH-1:0] sh_div   [NUM_CH];
  logic [WIDTH-1:0] sh_high  [NUM_CH];
  logic [WIDTH-1:0] cnt      [NUM_CH];
  logic [NUM_CH-1:0] pending;

  logic [WIDTH-1:0] nxt_act_div  [NUM_CH];
  logic [WIDTH-1:0] nxt_act_high [NUM_CH];
  logic [WIDTH-1:0] nxt_sh_div   [NUM_CH];
  logic [WIDTH-1:0] nxt_sh_high  [NUM_CH];
  logic [WIDTH-1:0] nxt_cnt      [NUM_CH];
  logic [WIDTH-1:0] ap_div       [NUM_CH];
  logic [WIDTH-1:0] ap_high      [NUM_CH];
  logic [NUM_CH-1:0] nxt_pending;
  logic [NUM_CH-1:0] nxt_clock;
  logic [NUM_CH-1:0] nxt_tick;
  logic [NUM_CH-1:0] wr_hit;

  logic             ch_ok;
  logic [WIDTH-1:0] w_div;

  assign ch_ok       = (cfg_ch <= CH_W'(NUM_CH - 1));
  assign w_div       = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
  assign cfg_pending = pending;

  // Per-channel next state: count/wrap, park when disabled, apply shadow at wrap/park.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_we && (cfg_ch == CH_W'(i));

      // Values that take effect at an apply point: a same-edge write bypasses
      // the shadow, otherwise a pending shadow wins over the active pair.
      if (wr_hit[i]) begin
        ap_div[i]  = w_div;
        ap_high[i] = cfg_high;
      end else if (pending[i]) begin
        ap_div[i]  = sh_div[i];
        ap_high[i] = sh_high[i];
      end else begin
        ap_div[i]  = act_div[i];
        ap_high[i] = act_high[i];
      end

      nxt_act_div[i]  = act_div[i];
      nxt_act_high[i] = act_high[i];
      nxt_sh_div[i]   = wr_hit[i] ? w_div    : sh_div[i];
      nxt_sh_high[i]  = wr_hit[i] ? cfg_high : sh_high[i];
      nxt_pending[i]  = pending[i] | wr_hit[i];
      nxt_cnt[i]      = cnt[i];
      nxt_clock[i]    = clock_out[i];
      nxt_tick[i]     = tick[i];

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
      if (sync_restart && ch_enable[i]) begin
        nxt_act_div[i]  = ap_div[i];
        nxt_act_high[i] = ap_high[i];
        nxt_pending[i]  = 1'b0;
        nxt_cnt[i]      = '0;
        nxt_tick[i]     = 1'b1;
        nxt_clock[i]    = (ap_high[i] != '0);
      end else
`endif
      if (!ch_enable[i]) begin
        nxt_act_div[i]  = ap_div[i];
        nxt_act_high[i] = ap_high[i];
        nxt_pending[i]  = 1'b0;
        nxt_cnt[i]      = ap_div[i] - ONE;
        nxt_clock[i]    = 1'b0;
        nxt_tick[i]     = 1'b0;
      end else if (cnt[i] >= act_div[i] - ONE) begin
        // Wrap is detected with the old divisor; the new period starts with
        // the applied values, so cnt=0 gives clock_out = (new high > 0).
        nxt_act_div[i]  = ap_div[i];
        nxt_act_high[i] = ap_high[i];
        nxt_pending[i]  = 1'b0;
        nxt_cnt[i]      = '0;
        nxt_tick[i]     = 1'b1;
        nxt_clock[i]    = (ap_high[i] != '0);
      end else begin
        nxt_cnt[i]      = cnt[i] + ONE;
        nxt_tick[i]     = 1'b0;
        nxt_clock[i]    = ((cnt[i] + ONE) < act_high[i]);
      end
    end
  end

  // State and registered outputs; reset overrides any simultaneous write.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_div[i]  <= RST_DIV;
        act_high[i] <= RST_HIGH;
        sh_div[i]   <= RST_DIV;
        sh_high[i]  <= RST_HIGH;
        cnt[i]      <= RST_DIV - ONE;
      end
      pending   <= '0;
      clock_out <= '0;
      tick      <= '0;
      cfg_ack   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_div[i]  <= nxt_act_div[i];
        act_high[i] <= nxt_act_high[i];
        sh_div[i]   <= nxt_sh_div[i];
        sh_high[i]  <= nxt_sh_high[i];
        cnt[i]      <= nxt_cnt[i];
      end
      pending   <= nxt_pending;
      clock_out <= nxt_clock;
      tick      <= nxt_tick;
      cfg_ack   <= cfg_we && ch_ok;
    end
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed self-checking bench for multi_clock_divider (DEFAULT_DIV=10).
// A second 3-channel instance exercises the out-of-range channel select.
module tb_multi_clock_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [31:0] cfg_high;
  logic        cfg_ack;
  logic [3:0]  cfg_pending;
  logic [3:0]  ch_enable;
  logic [3:0]  clock_out;
  logic [3:0]  tick;

  logic        b_we;
  logic [1:0]  b_ch;
  logic [31:0] b_div;
  logic [31:0] b_high;
  logic        b_ack;
  logic [2:0]  b_pending;
  logic [2:0]  b_enable;
  logic [2:0]  b_clock;
  logic [2:0]  b_tick;

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
  logic        sync_restart;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  multi_clock_divider #(.NUM_CH(4), .DEFAULT_DIV(10)) dut (
    .clock_50MHz (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_ack     (cfg_ack),
    .cfg_pending (cfg_pending),
    .ch_enable   (ch_enable),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    .sync_restart(sync_restart),
`endif
    .clock_out   (clock_out),
    .tick        (tick)
  );

  multi_clock_divider #(.NUM_CH(3), .DEFAULT_DIV(10)) dut_b (
    .clock_50MHz (clk),
    .reset       (reset),
    .cfg_we      (b_we),
    .cfg_ch      (b_ch),
    .cfg_div     (b_div),
    .cfg_high    (b_high),
    .cfg_ack     (b_ack),
    .cfg_pending (b_pending),
    .ch_enable   (b_enable),
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    .sync_restart(1'b0),
`endif
    .clock_out   (b_clock),
    .tick        (b_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d, input logic [31:0] h);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = d;
    cfg_high = h;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_high = '0;
    ch_enable = '0;
    b_we = 1'b0; b_ch = '0; b_div = '0; b_high = '0; b_enable = '0;
`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    sync_restart = 1'b0;
`endif
    step(); step();
    check("rst_clk",  32'(clock_out),   32'h0);
    check("rst_tick", 32'(tick),        32'h0);
    check("rst_ack",  32'(cfg_ack),     32'h0);
    check("rst_pend", 32'(cfg_pending), 32'h0);
    check("rst_b",    32'({b_clock, b_tick, b_pending, b_ack}), 32'h0);
    reset = 1'b0;
    step();
    check("park_clk", 32'(clock_out), 32'h0);

    // 1: default 10-cycle period, 5 high, tick on first enabled cycle.
    ch_enable = 4'b0001;
    for (int k = 0; k < 24; k++) begin
      step();
      check("t1_tick0", 32'(tick[0]),      32'((k % 10) == 0));
      check("t1_clk0",  32'(clock_out[0]), 32'((k % 10) < 5));
      check("t1_off",   32'({clock_out[3:1], tick[3:1]}), 32'h0);
    end

    // 2: ch0 at cnt=3; write div=4 high=1, old period completes first.
    wr(2'd0, 32'd4, 32'd1);
    step();
    cfg_we = 1'b0;
    check("t2_ack",   32'(cfg_ack),        32'h1);
    check("t2_pend",  32'(cfg_pending[0]), 32'h1);
    check("t2_clk",   32'(clock_out[0]),   32'h1);
    for (int j = 0; j < 5; j++) begin
      step();
      if (j == 0) check("t2_ack_off", 32'(cfg_ack), 32'h0);
      check("t2_old_clk",  32'(clock_out[0]),   32'h0);
      check("t2_old_tick", 32'(tick[0]),        32'h0);
      check("t2_old_pend", 32'(cfg_pending[0]), 32'h1);
    end
    for (int m = 0; m < 8; m++) begin
      step();
      check("t2_tick", 32'(tick[0]),        32'((m % 4) == 0));
      check("t2_clk",  32'(clock_out[0]),   32'((m % 4) == 0));
      check("t2_pend", 32'(cfg_pending[0]), 32'h0);
    end

    // 3: write div=0 high=0 on the wrap edge (bypass) -> period 2, always low.
    wr(2'd0, 32'd0, 32'd0);
    step();
    cfg_we = 1'b0;
    check("t3_tick", 32'(tick[0]),        32'h1);
    check("t3_clk",  32'(clock_out[0]),   32'h0);
    check("t3_pend", 32'(cfg_pending[0]), 32'h0);
    check("t3_ack",  32'(cfg_ack),        32'h1);
    for (int m = 1; m < 7; m++) begin
      step();
      check("t3_p2_tick", 32'(tick[0]),      32'((m % 2) == 0));
      check("t3_p2_clk",  32'(clock_out[0]), 32'h0);
    end
    wr(2'd0, 32'd4, 32'd7);
    step();
    cfg_we = 1'b0;
    check("t3_hi_pend", 32'(cfg_pending[0]), 32'h1);
    check("t3_hi_wait", 32'({clock_out[0], tick[0]}), 32'h0);
    for (int m = 0; m < 8; m++) begin
      step();
      check("t3_hi_tick", 32'(tick[0]),        32'((m % 4) == 0));
      check("t3_hi_clk",  32'(clock_out[0]),   32'h1);
      check("t3_hi_pend", 32'(cfg_pending[0]), 32'h0);
    end

    // 4: ch1 write on its exact wrap edge takes effect immediately.
    ch_enable = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t4_tick1", 32'(tick[1]),      32'(k == 0));
      check("t4_clk1",  32'(clock_out[1]), 32'(k < 5));
    end
    wr(2'd1, 32'd6, 32'd3);
    step();
    cfg_we = 1'b0;
    check("t4_tick", 32'(tick[1]),        32'h1);
    check("t4_clk",  32'(clock_out[1]),   32'h1);
    check("t4_pend", 32'(cfg_pending[1]), 32'h0);
    check("t4_ack",  32'(cfg_ack),        32'h1);
    for (int m = 1; m < 12; m++) begin
      step();
      check("t4_p6_tick", 32'(tick[1]),        32'((m % 6) == 0));
      check("t4_p6_clk",  32'(clock_out[1]),   32'((m % 6) < 3));
      check("t4_p6_pend", 32'(cfg_pending[1]), 32'h0);
    end

    // 5: park ch2 mid-high, then re-enable for a full fresh period.
    ch_enable = 4'b0111;
    step(); step(); step();
    check("t5_mid_clk", 32'(clock_out[2]), 32'h1);
    ch_enable = 4'b0011;
    step();
    check("t5_park", 32'({clock_out[2], tick[2]}), 32'h0);
    step();
    check("t5_park2", 32'({clock_out[2], tick[2]}), 32'h0);
    ch_enable = 4'b0111;
    for (int k = 0; k < 10; k++) begin
      step();
      check("t5_tick2", 32'(tick[2]),      32'(k == 0));
      check("t5_clk2",  32'(clock_out[2]), 32'(k < 5));
    end

    // 5b: out-of-range channel on a 3-channel instance is ignored.
    b_enable = 3'b111;
    step();
    check("t5b_tick", 32'(b_tick), 32'h7);
    step();
    b_we = 1'b1; b_ch = 2'd3; b_div = 32'd4; b_high = 32'd1;
    step();
    b_we = 1'b0;
    check("t5b_ack",  32'(b_ack),     32'h0);
    check("t5b_pend", 32'(b_pending), 32'h0);
    for (int k = 3; k < 11; k++) begin
      step();
      check("t5b_tick", 32'(b_tick),  (k == 10) ? 32'h7 : 32'h0);
      check("t5b_clk",  32'(b_clock), (k < 5 || k == 10) ? 32'h7 : 32'h0);
    end
    b_we = 1'b1; b_ch = 2'd2; b_div = 32'd4; b_high = 32'd1;
    step();
    b_we = 1'b0;
    check("t5b_ack_ok",  32'(b_ack),     32'h1);
    check("t5b_pend_ok", 32'(b_pending), 32'h4);

`ifdef MULTI_CLOCK_DIVIDER_SYNC_EN
    // 6: sync_restart aligns channels with div 10 and 5.
    wr(2'd0, 32'd10, 32'd5);
    step();
    wr(2'd1, 32'd5, 32'd2);
    step();
    cfg_we = 1'b0;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    check("t6_tick", 32'(tick),        32'h7);
    check("t6_clk",  32'(clock_out[1:0]), 32'h3);
    check("t6_pend", 32'(cfg_pending), 32'h0);
    for (int k = 1; k < 21; k++) begin
      step();
      check("t6_tick0", 32'(tick[0]),      32'((k % 10) == 0));
      check("t6_tick1", 32'(tick[1]),      32'((k % 5) == 0));
      check("t6_clk0",  32'(clock_out[0]), 32'((k % 10) < 5));
      check("t6_clk1",  32'(clock_out[1]), 32'((k % 5) < 2));
      check("t6_off3",  32'({clock_out[3], tick[3]}), 32'h0);
    end
`endif

    // Reset with a simultaneous write: reset wins, defaults restored.
    reset = 1'b1;
    wr(2'd0, 32'd4, 32'd1);
    step();
    reset = 1'b0;
    cfg_we = 1'b0;
    ch_enable = 4'b0001;
    check("rst2_ack",  32'(cfg_ack),     32'h0);
    check("rst2_pend", 32'(cfg_pending), 32'h0);
    check("rst2_out",  32'({clock_out, tick}), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("rst2_tick", 32'(tick[0]),      32'(k == 0));
      check("rst2_clk",  32'(clock_out[0]), 32'(k < 5));
      check("rst2_pend", 32'(cfg_pending),  32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
